// File: rtl/bus_decode_delay.sv
// bus_decode_delay: CPU host-bus address decode, slave strobes, read-data mux,
// and a tick-gated delay line that re-aligns video sync with the pixel pipeline.
module bus_decode_delay #(
   parameter int P_width  = 2,
   parameter int P_length = 4
) (
   input  logic               I_clock,
   input  logic               I_reset,
   input  logic [15:0]        I_addr,
   input  logic               I_phy2,
   input  logic               I_rdwr,
   input  logic [7:0]         I_mem_data,
   input  logic [7:0]         I_ppu_data,
   input  logic [7:0]         I_car_data,
   output logic [7:0]         O_rd_data,
   output logic [7:0]         O_addr_dec,
   output logic               O_mem_select,
   output logic               O_ppu_select,
   output logic               O_car_select,
   output logic               O_mem_wren,
   output logic               O_ppu_wren,
   output logic               O_ppu_rden,
   output logic               O_car_wren,
   input  logic               I_tick,
   input  logic [P_width-1:0] I_signal,
   output logic [P_width-1:0] O_signal
);
   logic [2:0]         region;
   logic               wren;
   logic               rden;
   logic [12:0]        unused_addr;
   logic [P_width-1:0] stage_q [P_length];
   logic [P_width-1:0] stage_d [P_length];

   assign region      = I_addr[15:13];
   assign unused_addr = I_addr[12:0];

   always_comb begin
      O_addr_dec   = 8'd1 << region;
      O_mem_select = O_addr_dec[0];
      O_ppu_select = O_addr_dec[1];
      O_car_select = |O_addr_dec[7:2];
      wren         = I_phy2 & ~I_rdwr;
      rden         = I_phy2 & I_rdwr;
      O_mem_wren   = wren & O_mem_select;
      O_ppu_wren   = wren & O_ppu_select;
      O_ppu_rden   = rden & O_ppu_select;
      O_car_wren   = wren & O_car_select;
      O_rd_data    = O_mem_select ? I_mem_data : O_ppu_select ? I_ppu_data : I_car_data;
   end

   // Stages only advance on a tick; otherwise the whole line holds.
   always_comb begin
      stage_d = stage_q;
      if (I_tick) begin
         stage_d[0] = I_signal;
         for (int i = 1; i < P_length; i++) stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge I_clock) begin
      if (I_reset) stage_q <= '{default: '0};
      else stage_q <= stage_d;
   end

   assign O_signal = stage_q[P_length-1];
endmodule

// File: tb/tb_bus_decode_delay.sv
// tb_bus_decode_delay: directed checks of decode, selects, strobes, read mux
// and the delay line (continuous tick, gated tick, reset flush).
module tb_bus_decode_delay;
   logic        I_clock = 1'b0;
   logic        I_reset = 1'b1;
   logic [15:0] I_addr = '0;
   logic        I_phy2 = 1'b0;
   logic        I_rdwr = 1'b1;
   logic [7:0]  I_mem_data = 8'h11;
   logic [7:0]  I_ppu_data = 8'h22;
   logic [7:0]  I_car_data = 8'h33;
   logic [7:0]  O_rd_data;
   logic [7:0]  O_addr_dec;
   logic        O_mem_select, O_ppu_select, O_car_select;
   logic        O_mem_wren, O_ppu_wren, O_ppu_rden, O_car_wren;
   logic        I_tick = 1'b0;
   logic [1:0]  I_signal = '0;
   logic [1:0]  O_signal;
   int          tests = 0;
   int          failed = 0;

   bus_decode_delay #(.P_width(2), .P_length(4)) dut (
      .I_clock(I_clock), .I_reset(I_reset), .I_addr(I_addr), .I_phy2(I_phy2),
      .I_rdwr(I_rdwr), .I_mem_data(I_mem_data), .I_ppu_data(I_ppu_data),
      .I_car_data(I_car_data), .O_rd_data(O_rd_data), .O_addr_dec(O_addr_dec),
      .O_mem_select(O_mem_select), .O_ppu_select(O_ppu_select),
      .O_car_select(O_car_select), .O_mem_wren(O_mem_wren), .O_ppu_wren(O_ppu_wren),
      .O_ppu_rden(O_ppu_rden), .O_car_wren(O_car_wren), .I_tick(I_tick),
      .I_signal(I_signal), .O_signal(O_signal)
   );

   always #5 I_clock = ~I_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge I_clock);
      @(negedge I_clock);
   endtask

   logic [15:0] sw_addr [12] = '{16'h0000, 16'h1FFF, 16'h2000, 16'h3FFF, 16'h4000, 16'h8000,
                                 16'hFFFF, 16'h0123, 16'h2002, 16'h6000, 16'hC000, 16'hA000};
   logic [7:0]  sw_dec  [12] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h10,
                                 8'h80, 8'h01, 8'h02, 8'h08, 8'h40, 8'h20};
   logic [2:0]  sw_sel  [12] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001,
                                 3'b001, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
   logic [7:0]  sw_rd   [12] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33,
                                 8'h33, 8'h11, 8'h22, 8'h33, 8'h33, 8'h33};
   logic [1:0]  gated_in  [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
   logic [1:0]  gated_exp [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};

   initial begin
      // Decode is live even while reset is held
      #1;
      chk("dec_in_reset", {24'd0, O_addr_dec}, 32'h01);
      cyc();
      chk("sig_reset", {30'd0, O_signal}, 32'h0);
      I_reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         I_addr = sw_addr[k];
         #1;
         chk($sformatf("dec_%04h", sw_addr[k]), {24'd0, O_addr_dec}, {24'd0, sw_dec[k]});
         chk($sformatf("sel_%04h", sw_addr[k]),
             {29'd0, O_mem_select, O_ppu_select, O_car_select}, {29'd0, sw_sel[k]});
         chk($sformatf("rd_%04h", sw_addr[k]), {24'd0, O_rd_data}, {24'd0, sw_rd[k]});
      end
      // Strobes packed as {mem_wren, ppu_wren, ppu_rden, car_wren}
      I_addr = 16'h2005; I_phy2 = 1'b1; I_rdwr = 1'b0; #1;
      chk("stb_ppu_wr", {28'd0, O_mem_wren, O_ppu_wren, O_ppu_rden, O_car_wren}, 32'b0100);
      I_rdwr = 1'b1; #1;
      chk("stb_ppu_rd", {28'd0, O_mem_wren, O_ppu_wren, O_ppu_rden, O_car_wren}, 32'b0010);
      chk("rd_indep_phy2", {24'd0, O_rd_data}, 32'h22);
      I_phy2 = 1'b0; I_rdwr = 1'b0; #1;
      chk("stb_idle", {28'd0, O_mem_wren, O_ppu_wren, O_ppu_rden, O_car_wren}, 32'b0000);
      I_phy2 = 1'b1; I_addr = 16'h8000; #1;
      chk("stb_car_wr", {28'd0, O_mem_wren, O_ppu_wren, O_ppu_rden, O_car_wren}, 32'b0001);
      I_addr = 16'h0004; #1;
      chk("stb_mem_wr", {28'd0, O_mem_wren, O_ppu_wren, O_ppu_rden, O_car_wren}, 32'b1000);
      I_addr = 16'h0004; I_rdwr = 1'b1; #1;
      chk("stb_mem_rd", {28'd0, O_mem_wren, O_ppu_wren, O_ppu_rden, O_car_wren}, 32'b0000);
      I_phy2 = 1'b0;
      // Continuous tick: 11 sampled on edge 1, visible after edge 4 only
      I_tick = 1'b1; I_signal = 2'b11;
      cyc();
      I_signal = 2'b00;
      chk("cont_e1", {30'd0, O_signal}, 32'h0);
      cyc(); chk("cont_e2", {30'd0, O_signal}, 32'h0);
      cyc(); chk("cont_e3", {30'd0, O_signal}, 32'h0);
      cyc(); chk("cont_e4", {30'd0, O_signal}, 32'h3);
      cyc(); chk("cont_e5", {30'd0, O_signal}, 32'h0);
      // Gated tick every 4th clock; non-tick input is junk and must be ignored
      for (int t = 0; t < 8; t++) begin
         for (int c = 0; c < 4; c++) begin
            I_tick = (c == 0);
            I_signal = (c == 0) ? gated_in[t] : 2'b11;
            cyc();
            chk($sformatf("gated_t%0d_c%0d", t, c), {30'd0, O_signal}, {30'd0, gated_exp[t]});
         end
      end
      // Reset mid-flight, asserted together with tick to prove priority
      I_tick = 1'b1; I_signal = 2'b11;
      cyc();
      I_signal = 2'b00;
      cyc();
      I_reset = 1'b1;
      cyc();
      I_reset = 1'b0;
      chk("flush_now", {30'd0, O_signal}, 32'h0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk($sformatf("flush_t%0d", k), {30'd0, O_signal}, 32'h0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
